// File: rtl/iobuf_sched_pkg.sv
// Shared types and helpers for the IobufVec bus scheduler.
package iobuf_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TURN,
        DRIVE,
        SAMPLE,
        RESP
    } state_e;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    // Width of a down-counter able to hold the largest of the three cycle counts.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/iobuf_rr_arb2.sv
// Two-requester round-robin arbiter; pointer names the preferred requester.
module iobuf_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       enable,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       ptr
);

    logic ptr_d, ptr_q;

    always_comb begin
        grant = '0;
        if (enable) begin
            if (valid[ptr_q]) begin
                grant[ptr_q] = 1'b1;
            end else if (valid[~ptr_q]) begin
                grant[~ptr_q] = 1'b1;
            end
        end
        ptr_d = ptr_q;
        // Winner becomes least preferred: pointer := winner ^ 1.
        if (advance && (|grant)) begin
            ptr_d = grant[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/iobuf_bus_sched.sv
// Schedules two requesters onto one IobufVec pad vector with turnaround on direction change.
module iobuf_bus_sched
    import iobuf_sched_pkg::*;
#(
    parameter int iovecWidth    = 8,
    parameter int TURN_CYCLES   = 2,
    parameter int HOLD_CYCLES   = 1,
    parameter int SAMPLE_CYCLES = 1
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_write,
    input  logic [iovecWidth-1:0] req0_wdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_write,
    input  logic [iovecWidth-1:0] req1_wdata,
    output logic                  rsp0_valid,
    output logic [iovecWidth-1:0] rsp0_rdata,
    output logic                  rsp1_valid,
    output logic [iovecWidth-1:0] rsp1_rdata,
    output logic [iovecWidth-1:0] pad_I,
    output logic                  pad_T,
    input  logic [iovecWidth-1:0] pad_O,
    output logic                  bus_stb
);

    localparam int CW = cnt_width(TURN_CYCLES, HOLD_CYCLES, SAMPLE_CYCLES);
    localparam logic [CW-1:0] TURN_LD   = CW'(TURN_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] SAMPLE_LD = CW'(SAMPLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    state_e                  state_d, state_q;
    logic [CW-1:0]           cnt_d, cnt_q;
    logic                    write_d, write_q;
    logic [iovecWidth-1:0]   wdata_d, wdata_q;
    logic                    id_d, id_q;
    logic                    dir_known_d, dir_known_q;
    logic                    last_dir_d, last_dir_q;
    logic                    pad_t_d, pad_t_q;
    logic [iovecWidth-1:0]   pad_i_d, pad_i_q;
    logic                    stb_d, stb_q;
    logic                    rsp0_valid_d, rsp0_valid_q;
    logic                    rsp1_valid_d, rsp1_valid_q;
    logic [iovecWidth-1:0]   rsp0_rdata_d, rsp0_rdata_q;
    logic [iovecWidth-1:0]   rsp1_rdata_d, rsp1_rdata_q;

    logic [1:0] grant;
    logic       rr_ptr;
    logic       accept;
    logic       sel_write;

    iobuf_rr_arb2 u_arb (
        .clk     (CLK),
        .rst_n   (nRST),
        .valid   ({req1_valid, req0_valid}),
        .enable  (nRST && (state_q == IDLE)),
        .advance (accept),
        .grant   (grant),
        .ptr     (rr_ptr)
    );

    assign accept     = |grant;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        id_d         = id_q;
        dir_known_d  = dir_known_q;
        last_dir_d   = last_dir_q;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;
        sel_write    = grant[1] ? req1_write : req0_write;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d     = sel_write;
                    wdata_d     = grant[1] ? req1_wdata : req0_wdata;
                    id_d        = grant[1];
                    dir_known_d = 1'b1;
                    last_dir_d  = sel_write ? DIR_WRITE : DIR_READ;
                    if (dir_known_q && (last_dir_d != last_dir_q)) begin
                        state_d = TURN;
                        cnt_d   = TURN_LD;
                    end else if (sel_write) begin
                        state_d = DRIVE;
                        cnt_d   = HOLD_LD;
                    end else begin
                        state_d = SAMPLE;
                        cnt_d   = SAMPLE_LD;
                    end
                end
            end
            TURN: begin
                if (cnt_q == '0) begin
                    state_d = write_q ? DRIVE : SAMPLE;
                    cnt_d   = write_q ? HOLD_LD : SAMPLE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DRIVE: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            SAMPLE: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (id_q) rsp1_rdata_d = pad_O;
                    else      rsp0_rdata_d = pad_O;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Pad and response outputs are registered, so derive them from the next state.
        pad_t_d      = (state_d != DRIVE);
        pad_i_d      = (state_d == DRIVE) ? wdata_d : '0;
        stb_d        = (state_d == DRIVE) || (state_d == SAMPLE);
        rsp0_valid_d = (state_d == RESP) && !id_d;
        rsp1_valid_d = (state_d == RESP) && id_d;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            id_q         <= 1'b0;
            dir_known_q  <= 1'b0;
            last_dir_q   <= DIR_READ;
            pad_t_q      <= 1'b1;
            pad_i_q      <= '0;
            stb_q        <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            id_q         <= id_d;
            dir_known_q  <= dir_known_d;
            last_dir_q   <= last_dir_d;
            pad_t_q      <= pad_t_d;
            pad_i_q      <= pad_i_d;
            stb_q        <= stb_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

    // Any transfer in flight was granted in IDLE, so the pointer must point away from it.
    a_rr_ptr: assert property (@(posedge CLK) disable iff (!nRST)
        (state_q != IDLE) |-> (rr_ptr == !id_q));

    assign pad_T      = pad_t_q;
    assign pad_I      = pad_i_q;
    assign bus_stb    = stb_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_iobuf_bus_sched.sv
// Scoreboard bench for iobuf_bus_sched: stimulus queues expectations, a negedge monitor checks them.
module tb_iobuf_bus_sched;

    localparam int W    = 8;
    localparam int TURN = 2;

    logic         CLK = 1'b0;
    logic         nRST = 1'b0;
    logic         req0_valid = 1'b0, req0_write = 1'b0;
    logic [W-1:0] req0_wdata = '0;
    logic         req1_valid = 1'b0, req1_write = 1'b0;
    logic [W-1:0] req1_wdata = '0;
    logic [W-1:0] pad_O = '0;
    logic         req0_ready, req1_ready, rsp0_valid, rsp1_valid, pad_T, bus_stb;
    logic [W-1:0] rsp0_rdata, rsp1_rdata, pad_I;

    iobuf_bus_sched #(
        .iovecWidth    (W),
        .TURN_CYCLES   (TURN),
        .HOLD_CYCLES   (1),
        .SAMPLE_CYCLES (1)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_write (req0_write),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_write (req1_write),
        .req1_wdata (req1_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .pad_I      (pad_I),
        .pad_T      (pad_T),
        .pad_O      (pad_O),
        .bus_stb    (bus_stb)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] d;
        int           c;
    } exp_t;

    exp_t drv_q[$];
    exp_t rsp0_q[$];
    exp_t rsp1_q[$];
    int   samp_q[$];
    int   grant_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    int   last_rsp0_cyc = 0;
    int   prev_rsp0_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        int   g;
        if (mon_en) begin
            if ((req0_ready | req1_ready) !== 1'b0) begin
                chk("ready_onehot", {31'b0, req0_ready & req1_ready}, 32'd0);
                if (grant_q.size() == 0) chk("grant_unexpected", grant_q.size(), 32'd1);
                else begin
                    g = grant_q.pop_front();
                    chk("grant_id", {31'b0, req1_ready}, g);
                end
            end
            if (pad_T !== 1'b1) begin
                chk("drv_stb", {31'b0, bus_stb}, 32'd1);
                if (drv_q.size() == 0) chk("drv_unexpected", drv_q.size(), 32'd1);
                else begin
                    e = drv_q.pop_front();
                    chk("drv_data", {24'b0, pad_I}, {24'b0, e.d});
                    chk("drv_cycle", cyc, e.c);
                end
            end else begin
                chk("released_pad_I", {24'b0, pad_I}, 32'd0);
                if (bus_stb !== 1'b0) begin
                    if (samp_q.size() == 0) chk("sample_unexpected", samp_q.size(), 32'd1);
                    else chk("sample_cycle", cyc, samp_q.pop_front());
                end
            end
            if (rsp0_valid !== 1'b0) begin
                prev_rsp0_cyc = last_rsp0_cyc;
                last_rsp0_cyc = cyc;
                if (rsp0_q.size() == 0) chk("rsp0_unexpected", rsp0_q.size(), 32'd1);
                else begin
                    e = rsp0_q.pop_front();
                    chk("rsp0_data", {24'b0, rsp0_rdata}, {24'b0, e.d});
                    chk("rsp0_cycle", cyc, e.c);
                end
            end
            if (rsp1_valid !== 1'b0) begin
                if (rsp1_q.size() == 0) chk("rsp1_unexpected", rsp1_q.size(), 32'd1);
                else begin
                    e = rsp1_q.pop_front();
                    chk("rsp1_data", {24'b0, rsp1_rdata}, {24'b0, e.d});
                    chk("rsp1_cycle", cyc, e.c);
                end
            end
        end
    end

    // Present one request, wait for acceptance, and queue the expected bus activity.
    task automatic issue(input bit id, input bit wr, input logic [W-1:0] d,
                         input bit turn, output int acc);
        bit got = 1'b0;
        int lat = turn ? TURN : 0;
        acc = -1;
        if (!wr) pad_O = d;
        if (id) begin
            req1_valid = 1'b1; req1_write = wr; req1_wdata = wr ? d : '0;
        end else begin
            req0_valid = 1'b1; req0_write = wr; req0_wdata = wr ? d : '0;
        end
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge CLK);
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
                got = 1'b1;
                acc = cyc;
                if (wr) drv_q.push_back('{d, acc + 1 + lat});
                else begin
                    samp_q.push_back(acc + 1 + lat);
                    if (id) rsp1_q.push_back('{d, acc + 2 + lat});
                    else    rsp0_q.push_back('{d, acc + 2 + lat});
                end
            end
        end
        if (!got) chk(id ? "accept_timeout1" : "accept_timeout0", {31'b0, got}, 32'd1);
        @(posedge CLK); #1;
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
        if (!wr) begin
            repeat (lat + 1) @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset(input bit hold_valid);
        nRST = 1'b0;
        req0_valid = hold_valid; req0_write = 1'b1; req0_wdata = 8'hFF;
        req1_valid = hold_valid; req1_write = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        mon_en = 1'b1;
        chk("rst_pad_T", {31'b0, pad_T}, 32'd1);
        chk("rst_pad_I", {24'b0, pad_I}, 32'd0);
        chk("rst_stb", {31'b0, bus_stb}, 32'd0);
        chk("rst_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
        chk("rst_rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("rst_rdata", {16'b0, rsp1_rdata, rsp0_rdata}, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        nRST = 1'b1;
        @(posedge CLK); #1;
    endtask

    initial begin
        int a, b, a0, a1, r1, r2;

        do_reset(1'b1);

        // Write then read from requester 0: second transfer crosses a direction change.
        grant_q.push_back(0);
        grant_q.push_back(0);
        issue(1'b0, 1'b1, 8'hA5, 1'b0, a);
        issue(1'b0, 1'b0, 8'h3C, 1'b1, b);
        chk("wr_rd_accept_gap", b - a, 32'd2);
        repeat (3) @(posedge CLK);
        #1;
        chk("rdata_held", {24'b0, rsp0_rdata}, 32'h3C);
        chk("rsp_pulse_ended", {31'b0, rsp0_valid}, 32'd0);

        // Reset clears the known direction, so writes after a read need no turnaround.
        do_reset(1'b0);
        grant_q.push_back(0);
        grant_q.push_back(1);
        fork
            issue(1'b0, 1'b1, 8'h11, 1'b0, a0);
            issue(1'b1, 1'b1, 8'h22, 1'b0, a1);
        join
        chk("both_accept_gap", a1 - a0, 32'd2);

        // Continuous contention alternates grants.
        grant_q.push_back(0);
        grant_q.push_back(1);
        grant_q.push_back(0);
        grant_q.push_back(1);
        fork
            begin
                issue(1'b0, 1'b1, 8'h31, 1'b0, a);
                issue(1'b0, 1'b1, 8'h33, 1'b0, a);
            end
            begin
                issue(1'b1, 1'b1, 8'h32, 1'b0, b);
                issue(1'b1, 1'b1, 8'h34, 1'b0, b);
            end
        join

        // Read run: only the first read turns the bus around.
        grant_q.push_back(0);
        grant_q.push_back(0);
        grant_q.push_back(0);
        grant_q.push_back(1);
        issue(1'b0, 1'b0, 8'h5A, 1'b1, a);
        issue(1'b0, 1'b0, 8'h55, 1'b0, r1);
        issue(1'b0, 1'b0, 8'hAA, 1'b0, r2);
        chk("rd_rd_accept_gap", r2 - r1, 32'd3);
        chk("rd_rd_rsp_gap", last_rsp0_cyc - prev_rsp0_cyc, 32'd3);
        issue(1'b1, 1'b0, 8'h77, 1'b0, a);
        repeat (2) @(posedge CLK);
        #1;
        chk("rdata1_held", {24'b0, rsp1_rdata}, 32'h77);
        chk("rdata0_unchanged", {24'b0, rsp0_rdata}, 32'hAA);

        // Reset in the middle of a drive cycle.
        grant_q.push_back(0);
        issue(1'b0, 1'b1, 8'hC3, 1'b1, a);
        repeat (2) @(posedge CLK);
        #1;
        chk("pre_rst_driving", {31'b0, pad_T}, 32'd0);
        nRST = 1'b0;
        req0_valid = 1'b1;
        req0_write = 1'b0;
        @(posedge CLK); #1;
        chk("midrst_pad_T", {31'b0, pad_T}, 32'd1);
        chk("midrst_stb", {31'b0, bus_stb}, 32'd0);
        chk("midrst_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
        chk("midrst_rsp", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
        req0_valid = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;
        grant_q.push_back(0);
        issue(1'b0, 1'b1, 8'hE7, 1'b0, a);

        for (int k = 0; k < 30 && (drv_q.size() + rsp0_q.size() + rsp1_q.size()
                                   + samp_q.size() + grant_q.size()) != 0; k++) begin
            @(posedge CLK);
        end
        #1;
        chk("drain_drv", drv_q.size(), 32'd0);
        chk("drain_sample", samp_q.size(), 32'd0);
        chk("drain_rsp0", rsp0_q.size(), 32'd0);
        chk("drain_rsp1", rsp1_q.size(), 32'd0);
        chk("drain_grant", grant_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
